// File: rtl/tube_r3_xfer_ctrl.sv
// rtl/tube_r3_xfer_ctrl.sv - Tube R3 NMI-paced block-transfer sequencer
//
// Moves a block of bytes between parasite memory and the Tube R3 FIFO,
// one or two bytes per PNMI. dir=0 reads the tube and writes memory,
// dir=1 reads memory and writes the tube.
//
// Ports:
//   p_phi2, h_rst_b              clock (posedge) and async active-low reset
//   start, dir, two_byte,
//   base_addr, length            transfer request, latched on an accepted start
//   abort                        terminate the running transfer at the next edge
//   p_nmi_b                      tube PNMI, active low, synchronous to p_phi2
//   t_addr, t_cs_b, t_rdnw,
//   t_wdata, t_rdata             tube parasite port (RNW style, R3 data register)
//   m_req, m_we, m_addr,
//   m_wdata, m_rdata, m_ack      req/ack memory port, m_ack is a 1-cycle pulse
//   busy, done, err              status: in progress, completion pulse, aborted
//   remaining, cur_addr          bytes still to move, next memory address
module tube_r3_xfer_ctrl #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              p_phi2,
  input  logic              h_rst_b,
  input  logic              start,
  input  logic              dir,
  input  logic              two_byte,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  length,
  input  logic              abort,
  input  logic              p_nmi_b,
  output logic [2:0]        t_addr,
  output logic              t_cs_b,
  output logic              t_rdnw,
  output logic [7:0]        t_wdata,
  input  logic [7:0]        t_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [7:0]        m_wdata,
  input  logic [7:0]        m_rdata,
  input  logic              m_ack,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  remaining,
  output logic [ADDR_W-1:0] cur_addr
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_NMI, S_TUBE_RD, S_MEM_WR, S_MEM_RD, S_TUBE_WR, S_GAP, S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_dir;
  logic              r_two;
  logic              r_err;
  logic [1:0]        r_burst;
  logic [7:0]        r_byte;
  logic [CNT_W-1:0]  r_remaining;
  logic [ADDR_W-1:0] r_cur_addr;

  logic              w_accept;
  logic              w_abort;
  logic              w_byte_done;
  logic              w_nmi_go;
  logic [CNT_W-1:0]  w_rem_dec;
  logic [1:0]        w_burst_dec;
  logic [1:0]        w_burst_init;

  // abort only acts on a running transfer; DONE is already terminating.
  // A start coincident with abort in IDLE is dropped.
  assign w_accept     = (r_state == S_IDLE) && start && !abort;
  assign w_abort      = abort && (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_nmi_go     = !w_abort && (r_state == S_WAIT_NMI) && !p_nmi_b;
  assign w_byte_done  = !w_abort && (((r_state == S_MEM_WR) && m_ack) || (r_state == S_TUBE_WR));
  assign w_rem_dec    = r_remaining - CNT_W'(1);
  assign w_burst_dec  = r_burst - 2'd1;
  // remaining is at least 1 whenever WAIT_NMI is reached
  assign w_burst_init = (r_two && (r_remaining > CNT_W'(1))) ? 2'd2 : 2'd1;

  always_ff @(posedge p_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    t_cs_b  = 1'b1;
    t_rdnw  = 1'b1;
    m_req   = 1'b0;
    m_we    = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_accept) w_next = (length == '0) ? S_DONE : S_WAIT_NMI;
      end
      S_WAIT_NMI: begin
        if (!p_nmi_b) w_next = r_dir ? S_MEM_RD : S_TUBE_RD;
      end
      S_TUBE_RD: begin
        t_cs_b = 1'b0;
        w_next = S_MEM_WR;
      end
      S_MEM_WR: begin
        m_req = 1'b1;
        m_we  = 1'b1;
        if (m_ack) begin
          if (w_burst_dec != 2'd0)  w_next = S_TUBE_RD;
          else if (w_rem_dec == '0) w_next = S_DONE;
          else                      w_next = S_GAP;
        end
      end
      S_MEM_RD: begin
        m_req = 1'b1;
        if (m_ack) w_next = S_TUBE_WR;
      end
      S_TUBE_WR: begin
        t_cs_b = 1'b0;
        t_rdnw = 1'b0;
        if (w_burst_dec != 2'd0)  w_next = S_MEM_RD;
        else if (w_rem_dec == '0) w_next = S_DONE;
        else                      w_next = S_GAP;
      end
      // one dead cycle so a stale PNMI from before the tube flag update is not seen
      S_GAP:  w_next = S_WAIT_NMI;
      S_DONE: begin
        busy   = 1'b0;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_DONE;
  end

  always_ff @(posedge p_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      r_dir       <= 1'b0;
      r_two       <= 1'b0;
      r_err       <= 1'b0;
      r_burst     <= 2'd0;
      r_byte      <= 8'h00;
      r_remaining <= '0;
      r_cur_addr  <= '0;
    end else begin
      if (w_accept) begin
        r_dir       <= dir;
        r_two       <= two_byte;
        r_remaining <= length;
        r_cur_addr  <= base_addr;
        r_err       <= 1'b0;
      end
      if (w_abort) r_err <= 1'b1;
      if (w_nmi_go) r_burst <= w_burst_init;
      if (!w_abort && (r_state == S_TUBE_RD)) r_byte <= t_rdata;
      if (!w_abort && (r_state == S_MEM_RD) && m_ack) r_byte <= m_rdata;
      if (w_byte_done) begin
        r_remaining <= w_rem_dec;
        r_cur_addr  <= r_cur_addr + ADDR_W'(1);
        r_burst     <= w_burst_dec;
      end
    end
  end

  assign t_addr    = 3'h5;
  assign t_wdata   = r_byte;
  assign m_wdata   = r_byte;
  assign m_addr    = r_cur_addr;
  assign err       = r_err;
  assign remaining = r_remaining;
  assign cur_addr  = r_cur_addr;

endmodule

// File: tb/tb_tube_r3_xfer_ctrl.sv
// tb/tb_tube_r3_xfer_ctrl.sv - self-checking bench for tube_r3_xfer_ctrl
module tb_tube_r3_xfer_ctrl;

    logic        p_phi2 = 1'b0;
    logic        h_rst_b;
    logic        start;
    logic        dir;
    logic        two_byte;
    logic [15:0] base_addr;
    logic [15:0] length;
    logic        abort;
    logic        p_nmi_b = 1'b1;
    logic [2:0]  t_addr;
    logic        t_cs_b;
    logic        t_rdnw;
    logic [7:0]  t_wdata;
    logic [7:0]  t_rdata = 8'h00;
    logic        m_req;
    logic        m_we;
    logic [15:0] m_addr;
    logic [7:0]  m_wdata;
    logic [7:0]  m_rdata = 8'h00;
    logic        m_ack = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] remaining;
    logic [15:0] cur_addr;

    int errors = 0;
    int checks = 0;

    always #5 p_phi2 = ~p_phi2;

    tube_r3_xfer_ctrl #(.ADDR_W(16), .CNT_W(16)) dut (
        .p_phi2(p_phi2), .h_rst_b(h_rst_b), .start(start), .dir(dir),
        .two_byte(two_byte), .base_addr(base_addr), .length(length),
        .abort(abort), .p_nmi_b(p_nmi_b), .t_addr(t_addr), .t_cs_b(t_cs_b),
        .t_rdnw(t_rdnw), .t_wdata(t_wdata), .t_rdata(t_rdata), .m_req(m_req),
        .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .m_ack(m_ack), .busy(busy), .done(done), .err(err),
        .remaining(remaining), .cur_addr(cur_addr)
    );

    // tube FIFO contents offered to reads, and memory contents as a function
    logic [7:0] src [256];
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        logic [7:0] t;
        t = a[7:0] * 8'd7;
        return (t + 8'h3c) ^ a[15:8];
    endfunction

    // controls owned by the test tasks
    bit ack_hold = 1'b0;
    bit ack_now  = 1'b0;
    bit nmi_en   = 1'b0;

    // observations owned by the responder; tasks only snapshot and read them
    int          rd_cnt = 0, done_cnt = 0, act_cnt = 0, b2b_viol = 0, req_viol = 0;
    logic [15:0] obs_mw_addr[$];
    logic [7:0]  obs_mw_data[$];
    logic [7:0]  obs_tw[$];
    int          obs_burst[$];
    bit          prev_tube = 1'b0, rd_pend = 1'b0;
    int          run_bytes = 0, ack_wait = 0;

    // Tube/memory responder and bus monitor. Runs mid-cycle; everything it
    // records completes at the following rising edge. A burst is a run of
    // consecutive cycles with tube or memory activity.
    always @(negedge p_phi2) begin
        if (!h_rst_b) begin
            prev_tube = 1'b0; rd_pend = 1'b0; run_bytes = 0; ack_wait = 0;
            m_ack = 1'b0; p_nmi_b = 1'b1;
        end else begin
            if (rd_pend) rd_cnt++;
            rd_pend = 1'b0;
            t_rdata = src[rd_cnt % 256];
            p_nmi_b = (nmi_en && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            if (done) done_cnt++;
            if (!t_cs_b && prev_tube) b2b_viol++;
            prev_tube = !t_cs_b;
            if (m_ack) begin
                m_ack = 1'b0;
                if (m_req) req_viol++;
                ack_wait = $urandom_range(0, 2);
            end else if (m_req && (ack_now || (!ack_hold && ack_wait == 0))) begin
                m_ack   = 1'b1;
                m_rdata = mem_byte(m_addr);
                if (m_we && !abort) begin
                    obs_mw_addr.push_back(m_addr);
                    obs_mw_data.push_back(m_wdata);
                    run_bytes++;
                end
            end else if (m_req && ack_wait > 0) begin
                ack_wait--;
            end
            if (!t_cs_b && t_rdnw && !abort) rd_pend = 1'b1;
            if (!t_cs_b && !t_rdnw && !abort) begin
                obs_tw.push_back(t_wdata);
                run_bytes++;
            end
            if (!t_cs_b || m_req) act_cnt++;
            else if (run_bytes > 0) begin
                obs_burst.push_back(run_bytes);
                run_bytes = 0;
            end
        end
    end

    task automatic test_reset;
        h_rst_b = 1'b0; start = 1'b0; dir = 1'b0; two_byte = 1'b0; abort = 1'b0;
        base_addr = 16'h0; length = 16'h0;
        #12;
        checks++;
        if ({t_cs_b, t_rdnw, m_req, m_we, busy, done, err} !== 7'b1100000)
            $display("FAIL reset_ctl: got %b expected 1100000", {t_cs_b, t_rdnw, m_req, m_we, busy, done, err});
        checks++;
        if ({t_wdata, m_wdata, m_addr, remaining, cur_addr} !== 64'h0)
            $display("FAIL reset_data: got %h expected 0", {t_wdata, m_wdata, m_addr, remaining, cur_addr});
        checks++;
        if (t_addr !== 3'h5) $display("FAIL t_addr: got %h expected 5", t_addr);
        if ({t_cs_b, t_rdnw, m_req, m_we, busy, done, err} !== 7'b1100000) errors++;
        if ({t_wdata, m_wdata, m_addr, remaining, cur_addr} !== 64'h0) errors++;
        if (t_addr !== 3'h5) errors++;
        @(negedge p_phi2);
        h_rst_b = 1'b1;
    endtask

    // Runs one transfer and compares it to a model built from the transfer rules:
    // bursts of min(1 or 2, remaining), byte i at address base+i (mod 2^16).
    task automatic run_xfer(input logic d, input logic tw, input logic [15:0] b,
                            input logic [15:0] l, input bit poke);
        int rd0, tw0, mw0, bu0, dn0, ac0, cyc, r, bb;
        bit seen;
        int exp_burst[$];
        logic [15:0] ea;
        rd0 = rd_cnt; tw0 = obs_tw.size(); mw0 = obs_mw_addr.size();
        bu0 = obs_burst.size(); dn0 = done_cnt; ac0 = act_cnt;
        r = int'(l);
        while (r > 0) begin
            bb = (tw && r >= 2) ? 2 : 1;
            exp_burst.push_back(bb);
            r -= bb;
        end
        ea = b + l;
        @(posedge p_phi2); #1;
        dir = d; two_byte = tw; base_addr = b; length = l; start = 1'b1; nmi_en = 1'b1;
        @(posedge p_phi2); #1;
        start = 1'b0; dir = ~d; two_byte = ~tw; base_addr = ~b; length = l + 16'd3;
        seen = 1'b0; cyc = 0;
        while (!seen && cyc < 3000) begin
            @(negedge p_phi2);
            cyc++;
            if (done) seen = 1'b1;
            else if (poke && cyc == 3 && busy) start = 1'b1;
            else start = 1'b0;
        end
        start = 1'b0;
        checks++;
        if (!seen) begin errors++; $display("FAIL done_timeout: got no done expected done within 3000 cycles"); end
        checks++;
        if (remaining !== 16'h0 || err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL end_status: got rem=%h err=%b busy=%b expected rem=0 err=0 busy=0", remaining, err, busy);
        end
        checks++;
        if (cur_addr !== ea) begin errors++; $display("FAIL end_addr: got %h expected %h", cur_addr, ea); end
        if (l == 16'h0) begin
            checks++;
            if (cyc > 2) begin errors++; $display("FAIL zero_len_latency: got %0d expected <=2", cyc); end
            checks++;
            if (act_cnt != ac0) begin errors++; $display("FAIL zero_len_activity: got %0d expected 0", act_cnt - ac0); end
        end
        nmi_en = 1'b0;
        @(negedge p_phi2);
        @(negedge p_phi2);
        checks++;
        if (done !== 1'b0 || done_cnt - dn0 != 1) begin
            errors++; $display("FAIL done_pulse: got count=%0d done=%b expected count=1 done=0", done_cnt - dn0, done);
        end
        checks++;
        if (d == 1'b0 && (obs_mw_addr.size() - mw0 != int'(l) || obs_tw.size() != tw0)) begin
            errors++; $display("FAIL mem_write_count: got %0d expected %0d", obs_mw_addr.size() - mw0, l);
        end else if (d == 1'b1 && (obs_tw.size() - tw0 != int'(l) || obs_mw_addr.size() != mw0)) begin
            errors++; $display("FAIL tube_write_count: got %0d expected %0d", obs_tw.size() - tw0, l);
        end else begin
            for (int i = 0; i < int'(l); i++) begin
                checks++;
                if (d == 1'b0 && (obs_mw_addr[mw0+i] !== b + 16'(i) || obs_mw_data[mw0+i] !== src[(rd0+i) % 256])) begin
                    errors++;
                    $display("FAIL mem_write[%0d]: got %h/%h expected %h/%h", i, obs_mw_addr[mw0+i],
                             obs_mw_data[mw0+i], b + 16'(i), src[(rd0+i) % 256]);
                end
                if (d == 1'b1 && obs_tw[tw0+i] !== mem_byte(b + 16'(i))) begin
                    errors++;
                    $display("FAIL tube_write[%0d]: got %h expected %h", i, obs_tw[tw0+i], mem_byte(b + 16'(i)));
                end
            end
        end
        checks++;
        if (obs_burst.size() - bu0 != exp_burst.size()) begin
            errors++; $display("FAIL burst_count: got %0d expected %0d", obs_burst.size() - bu0, exp_burst.size());
        end else begin
            for (int i = 0; i < exp_burst.size(); i++) begin
                checks++;
                if (obs_burst[bu0+i] != exp_burst[i]) begin
                    errors++; $display("FAIL burst[%0d]: got %0d expected %0d", i, obs_burst[bu0+i], exp_burst[i]);
                end
            end
        end
    endtask

    task automatic test_tube_to_mem;
        run_xfer(1'b0, 1'b0, 16'h1000, 16'd3, 1'b0);
    endtask

    task automatic test_mem_to_tube;
        run_xfer(1'b1, 1'b1, 16'h2000, 16'd5, 1'b0);
    endtask

    task automatic test_zero_length;
        run_xfer(1'b0, 1'b1, 16'h4444, 16'd0, 1'b0);
    endtask

    task automatic test_addr_wrap;
        run_xfer(1'b0, 1'b1, 16'hFFFF, 16'd2, 1'b0);
        run_xfer(1'b1, 1'b0, 16'hFFFE, 16'd3, 1'b0);
    endtask

    task automatic test_start_abort_idle;
        int dn0, ac0;
        dn0 = done_cnt; ac0 = act_cnt;
        @(posedge p_phi2); #1;
        dir = 1'b0; two_byte = 1'b0; base_addr = 16'h5000; length = 16'd3;
        start = 1'b1; abort = 1'b1; nmi_en = 1'b1;
        @(posedge p_phi2); #1;
        start = 1'b0; abort = 1'b0;
        repeat (6) @(negedge p_phi2);
        nmi_en = 1'b0;
        checks++;
        if (busy !== 1'b0 || done_cnt != dn0 || act_cnt != ac0) begin
            errors++; $display("FAIL start_abort_idle: got busy=%b dones=%0d act=%0d expected 0/0/0",
                               busy, done_cnt - dn0, act_cnt - ac0);
        end
    endtask

    task automatic test_abort;
        int mw0, dn0, cyc;
        logic [15:0] b;
        b = 16'(($urandom_range(0, 255) << 8) | 16'h0040);
        mw0 = obs_mw_addr.size(); dn0 = done_cnt;
        @(posedge p_phi2); #1;
        dir = 1'b0; two_byte = 1'b0; base_addr = b; length = 16'd6; start = 1'b1; nmi_en = 1'b1;
        @(posedge p_phi2); #1;
        start = 1'b0; length = 16'd9; base_addr = ~b;
        cyc = 0;
        while (obs_mw_addr.size() - mw0 < 2 && cyc < 2000) begin @(negedge p_phi2); cyc++; end
        ack_hold = 1'b1;
        cyc = 0;
        while (!m_req && cyc < 2000) begin @(negedge p_phi2); cyc++; end
        checks++;
        if (!m_req || obs_mw_addr.size() - mw0 != 2) begin
            errors++; $display("FAIL abort_setup: got req=%b writes=%0d expected req=1 writes=2", m_req, obs_mw_addr.size() - mw0);
        end
        start = 1'b1;
        @(negedge p_phi2);
        start = 1'b0;
        @(posedge p_phi2); #1;
        abort = 1'b1; ack_now = 1'b1;
        @(posedge p_phi2); #1;
        abort = 1'b0; ack_now = 1'b0; ack_hold = 1'b0; nmi_en = 1'b0;
        checks++;
        if (m_req !== 1'b0 || done !== 1'b1 || err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_edge: got req=%b done=%b err=%b busy=%b expected 0 1 1 0", m_req, done, err, busy);
        end
        checks++;
        if (remaining !== 16'd4 || cur_addr !== b + 16'd2) begin
            errors++; $display("FAIL abort_freeze: got rem=%h addr=%h expected rem=4 addr=%h", remaining, cur_addr, b + 16'd2);
        end
        @(posedge p_phi2); #1;
        checks++;
        if (done !== 1'b0 || err !== 1'b1 || busy !== 1'b0 || remaining !== 16'd4) begin
            errors++; $display("FAIL abort_after: got done=%b err=%b busy=%b rem=%h expected 0 1 0 4", done, err, busy, remaining);
        end
        @(negedge p_phi2);
        checks++;
        if (obs_mw_addr.size() - mw0 != 2 || done_cnt - dn0 != 1) begin
            errors++; $display("FAIL abort_counts: got writes=%0d dones=%0d expected 2 1", obs_mw_addr.size() - mw0, done_cnt - dn0);
        end
    endtask

    task automatic test_async_reset;
        int cyc;
        bit hit;
        @(posedge p_phi2); #1;
        dir = 1'b1; two_byte = 1'b1; base_addr = 16'h3000; length = 16'd4; start = 1'b1; nmi_en = 1'b1;
        @(posedge p_phi2); #1;
        start = 1'b0;
        hit = 1'b0; cyc = 0;
        while (!hit && cyc < 500) begin
            @(negedge p_phi2);
            cyc++;
            if (!t_cs_b && !t_rdnw) hit = 1'b1;
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL async_setup: got no tube write expected one"); end
        #2 h_rst_b = 1'b0;
        #1;
        checks++;
        if (t_cs_b !== 1'b1 || busy !== 1'b0 || m_req !== 1'b0 || remaining !== 16'h0 || cur_addr !== 16'h0) begin
            errors++; $display("FAIL async_reset: got cs_b=%b busy=%b req=%b rem=%h addr=%h expected 1 0 0 0 0",
                               t_cs_b, busy, m_req, remaining, cur_addr);
        end
        nmi_en = 1'b0;
        @(negedge p_phi2);
        h_rst_b = 1'b1;
        repeat (3) @(negedge p_phi2);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || t_cs_b !== 1'b1 || m_req !== 1'b0) begin
            errors++; $display("FAIL async_release: got busy=%b done=%b cs_b=%b req=%b expected 0 0 1 0", busy, done, t_cs_b, m_req);
        end
    endtask

    task automatic test_random;
        logic        d, tw;
        logic [15:0] b, l;
        for (int k = 0; k < 10; k++) begin
            d  = 1'($urandom_range(0, 1));
            tw = 1'($urandom_range(0, 1));
            b  = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 4)) : 16'($urandom);
            l  = 16'($urandom_range(0, 9));
            run_xfer(d, tw, b, l, 1'b1);
        end
    endtask

    task automatic test_protocol;
        checks++;
        if (b2b_viol != 0) begin errors++; $display("FAIL tube_back_to_back: got %0d expected 0", b2b_viol); end
        checks++;
        if (req_viol != 0) begin errors++; $display("FAIL req_after_ack: got %0d expected 0", req_viol); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) src[i] = 8'($urandom);
        test_reset;
        test_tube_to_mem;
        test_mem_to_tube;
        test_zero_length;
        test_addr_wrap;
        test_start_abort_idle;
        test_abort;
        run_xfer(1'b1, 1'b0, 16'h0800, 16'd2, 1'b0);
        test_async_reset;
        run_xfer(1'b0, 1'b1, 16'h0100, 16'd4, 1'b0);
        test_random;
        test_protocol;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
